// File: rtl/centroid_accumulator.sv
// centroid_accumulator: running sum and sample count for one K-means cluster.
// Accepts unsigned coordinate samples, closes a group on in_last or flush, and
// presents {sum, count, ovf} to the centroid divider over a valid/ready handshake.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous clear (discards any pending result)
//   in_valid/in_ready/in_data/in_last   sample stream
//   flush          close the current group without a sample
//   out_valid/out_ready                 result handshake
//   out_sum, out_count, out_ovf         result payload (valid while out_valid=1)
module centroid_accumulator #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SUM_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             live_q;
  logic             accept;
  logic             full;

  // live_q keeps in_ready low while reset is held and lets it rise one cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  assign in_ready = live_q && (state_q == ACC) && !clr;
  assign accept   = in_valid && in_ready;
  assign full     = (count_q == CNT_MAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush closes the group whether or not a sample is accepted
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACC;
    end else begin
      case (state_q)
        ACC: begin
          if ((accept && in_last) || flush) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // Accumulator update; a sample arriving with count full is dropped and flagged
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      sum_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (!full) begin
              sum_d   = sum_q + SUM_W'(in_data);
              count_d = count_q + CNT_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          sum_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  // Accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs are straight decodes of registered state
  always_comb begin
    out_valid = (state_q == HOLD);
    out_sum   = sum_q;
    out_count = count_q;
    out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_centroid_accumulator.sv
// Self-checking bench for centroid_accumulator: table of groups with expected
// results pushed to a scoreboard, plus backpressure, clear and reset sequences.
module tb_centroid_accumulator;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned SUM_W  = 24;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  centroid_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [15:0] d0, d1, d2, fill;
    bit          close_flush;
    logic [23:0] exp_sum;
    logic [7:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] samp(input vec_t v, input int i);
    case (i)
      0:       return v.d0;
      1:       return v.d1;
      2:       return v.d2;
      default: return v.fill;
    endcase
  endfunction

  // Drive one group; returns at the negedge after the closing edge
  task automatic run_group(input vec_t v, input bit push);
    int t;
    res_t r;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (!in_ready) check({v.name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    if (push) begin
      r.sum = v.exp_sum;
      r.cnt = v.exp_cnt;
      r.ovf = v.exp_ovf;
      sb.push_back(r);
    end
    if (v.n == 0) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end else begin
      for (int i = 0; i < v.n; i++) begin
        in_valid = 1'b1;
        in_data  = samp(v, i);
        in_last  = (i == v.n - 1) && !v.close_flush;
        flush    = (i == v.n - 1) && v.close_flush;
        @(negedge clk);
        check({v.name, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      flush    = 1'b0;
      in_data  = '0;
    end
    @(negedge clk);
    check({v.name, "_latency_out_valid"}, 32'(out_valid), 32'd1);
    check({v.name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  // Wait (bounded) for the handshake at a negedge, compare with scoreboard, pass the edge
  task automatic collect(input string name);
    int t;
    res_t r;
    t = 0;
    while (!(out_valid && out_ready) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (!(out_valid && out_ready)) begin
      check({name, "_handshake_timeout"}, 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      check({name, "_sb_underflow"}, 32'd0, 32'd1);
    end else begin
      r = sb.pop_front();
      check({name, "_out_sum"},   32'(out_sum),   32'(r.sum));
      check({name, "_out_count"}, 32'(out_count), 32'(r.cnt));
      check({name, "_out_ovf"},   32'(out_ovf),   32'(r.ovf));
    end
    tick();
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    vecs[0] = '{"basic",       3,   16'h0003, 16'h0010, 16'h1000, 16'h0000, 1'b0, 24'h001013, 8'd3,   1'b0};
    vecs[1] = '{"max_group",   255, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 24'hFEFF01, 8'hFF,  1'b0};
    vecs[2] = '{"ovf_drop",    256, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 24'h0000FF, 8'hFF,  1'b1};
    vecs[3] = '{"flush_empty", 0,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 24'h000000, 8'd0,   1'b0};
    vecs[4] = '{"flush_samp",  2,   16'h0001, 16'h0009, 16'h0000, 16'h0000, 1'b1, 24'h00000A, 8'd2,   1'b0};
    vecs[5] = '{"single",      1,   16'h0004, 16'h0000, 16'h0000, 16'h0000, 1'b0, 24'h000004, 8'd1,   1'b0};

    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven groups
    for (int k = 0; k < 6; k++) begin
      run_group(vecs[k], 1'b1);
      collect(vecs[k].name);
      check({vecs[k].name, "_after_out_valid"}, 32'(out_valid), 32'd0);
    end

    // Backpressure: result held stable, input pulses ignored
    out_ready = 1'b0;
    v = '{"bp", 2, 16'd5, 16'd7, 16'd0, 16'd0, 1'b0, 24'd12, 8'd2, 1'b0};
    run_group(v, 1'b1);
    for (int c = 0; c < 10; c++) begin
      tick();
      in_valid = c[0];
      in_data  = 16'h0100;
      in_last  = 1'b1;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum",   32'(out_sum),   32'd12);
      check("bp_out_count", 32'(out_count), 32'd2);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    collect("bp");
    @(negedge clk);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready",  32'(in_ready),  32'd1);
    tick();
    run_group(vecs[5], 1'b1);
    collect("bp_next");

    // Clear after two samples; sample offered during clr must be refused
    in_valid = 1'b1;
    in_data  = 16'h0055;
    tick();
    in_data  = 16'h0066;
    tick();
    in_data  = 16'h0077;
    clr      = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready), 32'd0);
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    check("clr_out_valid", 32'(out_valid), 32'd0);
    check("clr_out_sum",   32'(out_sum),   32'd0);
    check("clr_out_count", 32'(out_count), 32'd0);
    tick();
    run_group(vecs[5], 1'b1);
    collect("after_clr");

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    v = '{"rst_hold", 2, 16'd5, 16'd7, 16'd0, 16'd0, 1'b0, 24'd12, 8'd2, 1'b0};
    run_group(v, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_sum",   32'(out_sum),   32'd0);
    check("async_rst_out_count", 32'(out_count), 32'd0);
    check("async_rst_out_ovf",   32'(out_ovf),   32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("rerelease_in_ready",  32'(in_ready),  32'd1);
    check("rerelease_out_valid", 32'(out_valid), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
